// File: rtl/io_input_port_if.sv
// CPU-side read bus for the memory-mapped switch input port.
interface io_input_port_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] io_read_data;
    logic              rd_valid;

    modport master (output rd_en, output addr, input io_read_data, input rd_valid);
    modport slave  (input rd_en, input addr, output io_read_data, output rd_valid);
endinterface

// File: rtl/io_input_port.sv
// Switch input peripheral: 2-flop sync, per-port debounce with change flags,
// and a registered read port decoded at I/O addresses 0x80-0x8C.
module io_input_port #(
    parameter int unsigned IN_W      = 4,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 20
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IN_W-1:0] in_port0,
    input  logic [IN_W-1:0] in_port1,
    io_input_port_if.slave  bus,
    output logic [IN_W-1:0] stable0,
    output logic [IN_W-1:0] stable1,
    output logic            change_irq
);
    localparam int unsigned NPORT  = 2;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [IN_W-1:0]  raw      [NPORT];
    logic [IN_W-1:0]  meta_q   [NPORT];
    logic [IN_W-1:0]  sync_q   [NPORT];
    logic [IN_W-1:0]  stable_q [NPORT];
    logic [CNT_W-1:0] cnt_q    [NPORT];
    logic [NPORT-1:0] flag_q;

    logic [NPORT-1:0]  accept_c;
    logic [NPORT-1:0]  clr_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              rd_hit_c;

    assign raw[0]     = in_port0;
    assign raw[1]     = in_port1;
    assign stable0    = stable_q[0];
    assign stable1    = stable_q[1];
    assign change_irq = |flag_q;

    // Read decode from pre-edge state; unmapped reads return zero.
    always_comb begin
        accept_c  = '0;
        clr_c     = '0;
        rd_data_c = '0;
        rd_hit_c  = bus.rd_en && bus.addr[7];
        for (int p = 0; p < NPORT; p++) begin
            accept_c[p] = (sync_q[p] != stable_q[p]) && (cnt_q[p] == CNT_MAX);
        end
        if (rd_hit_c) begin
            unique case (bus.addr[3:2])
                2'd0: begin
                    rd_data_c = DATA_W'(stable_q[0]);
                    clr_c     = 2'b01;
                end
                2'd1: begin
                    rd_data_c = DATA_W'(stable_q[1]);
                    clr_c     = 2'b10;
                end
                2'd2: rd_data_c = DATA_W'(flag_q);
                default: begin
                    rd_data_c = DATA_W'({stable_q[1], stable_q[0]});
                    clr_c     = 2'b11;
                end
            endcase
        end
    end

    // Debounce compares only against stable, so a third value keeps counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < NPORT; p++) begin
                meta_q[p]   <= '0;
                sync_q[p]   <= '0;
                stable_q[p] <= '0;
                cnt_q[p]    <= '0;
            end
            flag_q           <= '0;
            bus.io_read_data <= '0;
            bus.rd_valid     <= 1'b0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                meta_q[p] <= raw[p];
                sync_q[p] <= meta_q[p];
                if (sync_q[p] == stable_q[p]) begin
                    cnt_q[p] <= '0;
                end else if (cnt_q[p] == CNT_MAX) begin
                    stable_q[p] <= sync_q[p];
                    cnt_q[p]    <= '0;
                end else begin
                    cnt_q[p] <= cnt_q[p] + CNT_W'(1);
                end
            end
            // A set on the same edge as a read-clear wins.
            flag_q <= (flag_q & ~clr_c) | accept_c;
            if (bus.rd_en) begin
                bus.io_read_data <= rd_data_c;
                bus.rd_valid     <= 1'b1;
            end else begin
                bus.rd_valid <= 1'b0;
            end
        end
    end
endmodule
